// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic functional-unit schedulers.
// Provides the arithmetic_type encodings, default datapath widths and the
// issue-packet struct that describes one arithmetic op at its default widths.
package arith_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned TAG_W_DEF = 6;

    typedef logic [2:0] arith_type_t;

    // ADD and SUB share an encoding; additional_info selects SUB.
    localparam arith_type_t ARITH_ADD_SUB = 3'd0;
    localparam arith_type_t ARITH_SLT     = 3'd2;
    localparam arith_type_t ARITH_SLTU    = 3'd3;

    typedef struct packed {
        logic                   additional_info;
        arith_type_t            arithmetic_type;
        logic [XLEN_DEF-1:0]    rs1;
        logic [XLEN_DEF-1:0]    rs2;
        logic [TAG_W_DEF-1:0]   tag;
    } issue_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req_i         per-requester request vector
//   en_i          grant enable; with en_i=0 no grant is given and the pointer holds
//   gnt_o         one-hot grant (or zero)
//   gnt_idx_o     index of the winning requester (valid when gnt_o != 0)
// After a grant to g the pointer moves to g+1 (wrapping), so g has lowest priority next.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       en_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;
    logic            found;

    // NUM_REQ is a power of two, so pointer arithmetic wraps by truncation.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr_q + IdxW'(i);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = cand;
            end
        end
        if (found && en_i) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found && en_i) begin
            ptr_d = gnt_idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arith_fu_issue_arbiter.sv
// Shares one arithmetic FU between NUM_REQ reservation-station requesters.
// Ports:
//   clk_i, rst_i, flush_i           clock, async active-high reset, synchronous squash
//   req_*_i / req_ready_o           packed per-requester ops and one-hot grant
//   fu_*_o                          operands/control of the granted op to the FU
//   fu_valid_out_i, fu_result_i     FU completion, FU_LAT cycles after issue
//   cdb_valid_o/ready_i/tag_o/result_o  registered head of the result buffer
// A credit counter bounds ops in the FU plus buffered results, so the buffer never overflows.
module arith_fu_issue_arbiter
    import arith_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TAG_W      = TAG_W_DEF,
    parameter int unsigned FU_LAT     = 1,
    parameter int unsigned OBUF_DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0]       req_additional_info_i,
    input  logic [3*NUM_REQ-1:0]     req_arithmetic_type_i,
    input  logic [XLEN*NUM_REQ-1:0]  req_rs1_i,
    input  logic [XLEN*NUM_REQ-1:0]  req_rs2_i,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag_i,
    output logic                     fu_valid_in_o,
    output logic                     fu_additional_info_o,
    output arith_type_t              fu_arithmetic_type_o,
    output logic [XLEN-1:0]          fu_rs1_o,
    output logic [XLEN-1:0]          fu_rs2_o,
    input  logic                     fu_valid_out_i,
    input  logic [XLEN-1:0]          fu_result_i,
    output logic                     cdb_valid_o,
    input  logic                     cdb_ready_i,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [XLEN-1:0]          cdb_result_o
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned CredW = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned PtrW  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

    logic [CredW-1:0] credits_q, credits_d;
    logic [IdxW-1:0]  gnt_idx;
    logic [TAG_W-1:0] gnt_tag;
    logic             issue, push, pop, arb_en;

    // ---------------- Issue ----------------
    assign pop = cdb_valid_o & cdb_ready_i;
    // A same-cycle CDB pop frees a slot, so it can back an issue at zero credits;
    // this is what sustains one op per cycle when FU_LAT+1 == OBUF_DEPTH.
    assign arb_en = ((credits_q != '0) | pop) & ~flush_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid_i),
        .en_i      (arb_en),
        .gnt_o     (req_ready_o),
        .gnt_idx_o (gnt_idx)
    );

    assign issue                = |req_ready_o;
    assign fu_valid_in_o        = issue;
    assign fu_additional_info_o = req_additional_info_i[gnt_idx];
    assign fu_arithmetic_type_o = req_arithmetic_type_i[3*gnt_idx +: 3];
    assign fu_rs1_o             = req_rs1_i[XLEN*gnt_idx +: XLEN];
    assign fu_rs2_o             = req_rs2_i[XLEN*gnt_idx +: XLEN];
    assign gnt_tag              = req_tag_i[TAG_W*gnt_idx +: TAG_W];

    // ---------------- Tag pipe ----------------
    logic [FU_LAT-1:0] pipe_vld_q;
    logic [FU_LAT-1:0] fu_vld_raw_q;  // ignores flush; tracks what the FU itself will emit
    logic [TAG_W-1:0]  pipe_tag_q [FU_LAT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld_q   <= '0;
            fu_vld_raw_q <= '0;
            for (int k = 0; k < FU_LAT; k++) begin
                pipe_tag_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0]   <= issue & ~flush_i;
            fu_vld_raw_q[0] <= issue;
            pipe_tag_q[0]   <= gnt_tag;
            for (int k = 1; k < FU_LAT; k++) begin
                pipe_vld_q[k]   <= pipe_vld_q[k-1] & ~flush_i;
                fu_vld_raw_q[k] <= fu_vld_raw_q[k-1];
                pipe_tag_q[k]   <= pipe_tag_q[k-1];
            end
        end
    end

    // Results landing in the flush cycle are squashed along with the buffer.
    assign push = pipe_vld_q[FU_LAT-1] & ~flush_i;

    // ---------------- Credits ----------------
    always_comb begin
        credits_d = credits_q;
        if (flush_i) begin
            credits_d = CredW'(OBUF_DEPTH);
        end else begin
            credits_d = credits_q - CredW'(issue) + CredW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits_q <= CredW'(OBUF_DEPTH);
        end else begin
            credits_q <= credits_d;
        end
    end

    // ---------------- Output buffer ----------------
    logic [TAG_W-1:0] buf_tag_q [OBUF_DEPTH];
    logic [XLEN-1:0]  buf_res_q [OBUF_DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CredW-1:0] count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OBUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < OBUF_DEPTH; k++) begin
                buf_tag_q[k] <= '0;
                buf_res_q[k] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                buf_tag_q[wr_ptr_q] <= pipe_tag_q[FU_LAT-1];
                buf_res_q[wr_ptr_q] <= fu_result_i;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CredW'(push) - CredW'(pop);
        end
    end

    assign cdb_valid_o  = (count_q != '0);
    assign cdb_tag_o    = buf_tag_q[rd_ptr_q];
    assign cdb_result_o = buf_res_q[rd_ptr_q];

    // FU completions must line up with what was issued FU_LAT cycles earlier.
    a_fu_valid_align: assert property (@(posedge clk_i) disable iff (rst_i)
        fu_valid_out_i == fu_vld_raw_q[FU_LAT-1]);

    // Credits make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && count_q == CredW'(OBUF_DEPTH)));

endmodule

// File: tb/tb_arith_fu_issue_arbiter.sv
// Directed bench for arith_fu_issue_arbiter with a 1-cycle arithmetic FU model.
module tb_arith_fu_issue_arbiter;
    import arith_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned XL = 32;
    localparam int unsigned TW = 6;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [NR-1:0]   req_valid, req_ready, req_ai;
    logic [3*NR-1:0] req_type;
    logic [XL*NR-1:0] req_rs1, req_rs2;
    logic [TW*NR-1:0] req_tag;
    logic            fu_vi, fu_ai, fu_vo;
    arith_type_t     fu_type;
    logic [XL-1:0]   fu_rs1, fu_rs2, fu_res;
    logic            cdb_valid, cdb_ready;
    logic [TW-1:0]   cdb_tag;
    logic [XL-1:0]   cdb_result;

    issue_pkt_t pkt [NR];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_ai   = '0;
        req_type = '0;
        req_rs1  = '0;
        req_rs2  = '0;
        req_tag  = '0;
        for (int i = 0; i < NR; i++) begin
            req_ai[i]          = pkt[i].additional_info;
            req_type[3*i +: 3] = pkt[i].arithmetic_type;
            req_rs1[XL*i +: XL] = pkt[i].rs1;
            req_rs2[XL*i +: XL] = pkt[i].rs2;
            req_tag[TW*i +: TW] = pkt[i].tag;
        end
    end

    // Arithmetic FU model, latency 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fu_vo  <= 1'b0;
            fu_res <= '0;
        end else begin
            fu_vo <= fu_vi;
            case (fu_type)
                ARITH_SLT:  fu_res <= {31'd0, $signed(fu_rs1) < $signed(fu_rs2)};
                ARITH_SLTU: fu_res <= {31'd0, fu_rs1 < fu_rs2};
                default:    fu_res <= fu_ai ? fu_rs1 - fu_rs2 : fu_rs1 + fu_rs2;
            endcase
        end
    end

    arith_fu_issue_arbiter #(
        .XLEN       (XL),
        .NUM_REQ    (NR),
        .TAG_W      (TW),
        .FU_LAT     (1),
        .OBUF_DEPTH (2)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready),
        .req_additional_info_i (req_ai),
        .req_arithmetic_type_i (req_type),
        .req_rs1_i             (req_rs1),
        .req_rs2_i             (req_rs2),
        .req_tag_i             (req_tag),
        .fu_valid_in_o         (fu_vi),
        .fu_additional_info_o  (fu_ai),
        .fu_arithmetic_type_o  (fu_type),
        .fu_rs1_o              (fu_rs1),
        .fu_rs2_o              (fu_rs2),
        .fu_valid_out_i        (fu_vo),
        .fu_result_i           (fu_res),
        .cdb_valid_o           (cdb_valid),
        .cdb_ready_i           (cdb_ready),
        .cdb_tag_o             (cdb_tag),
        .cdb_result_o          (cdb_result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cdb(input string tag, input logic [TW-1:0] t, input logic [XL-1:0] r);
        chk({tag, "_valid"}, cdb_valid, 1);
        chk({tag, "_tag"}, cdb_tag, t);
        chk({tag, "_result"}, cdb_result, r);
    endtask

    function automatic issue_pkt_t mk(input logic ai, input arith_type_t ty,
                                      input logic [XL-1:0] a, input logic [XL-1:0] b,
                                      input logic [TW-1:0] t);
        issue_pkt_t p;
        p.additional_info = ai;
        p.arithmetic_type = ty;
        p.rs1             = a;
        p.rs2             = b;
        p.tag             = t;
        return p;
    endfunction

    task automatic base_pkts;
        pkt[0] = mk(1'b0, ARITH_ADD_SUB, 32'd10, 32'd20, 6'd1);
        pkt[1] = mk(1'b0, ARITH_ADD_SUB, 32'h7FFF_FFFF, 32'd1, 6'd5);
        pkt[2] = mk(1'b0, ARITH_ADD_SUB, 32'd100, 32'd200, 6'd2);
        pkt[3] = mk(1'b0, ARITH_ADD_SUB, 32'd3, 32'd4, 6'd7);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        cdb_ready = 1'b1;
        base_pkts();
        #12;
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_result", cdb_result, 0);
        chk("rst_credits", dut.credits_q, 2);
        rst = 1'b0;

        // Round-robin over all requesters, ADD, CDB always ready.
        req_valid = 4'hF;
        #1;
        chk("rr_gnt0", req_ready, 4'b0001);
        chk("rr_fu_valid", fu_vi, 1);
        chk("rr_fu_rs1", fu_rs1, 32'd10);
        tick();
        chk("rr_gnt1", req_ready, 4'b0010);
        chk("rr_fu_rs1_r1", fu_rs1, 32'h7FFF_FFFF);
        chk("rr_cdb_empty", cdb_valid, 0);
        tick();
        chk("rr_gnt2", req_ready, 4'b0100);
        chk_cdb("rr_res_r0", 6'd1, 32'd30);
        tick();
        chk("rr_gnt3", req_ready, 4'b1000);
        chk_cdb("rr_res_r1", 6'd5, 32'h8000_0000);
        tick();
        chk("rr_gnt0_wrap", req_ready, 4'b0001);
        chk_cdb("rr_res_r2", 6'd2, 32'd300);
        tick();
        req_valid = '0;
        #1;
        chk("rr_no_gnt", req_ready, 4'b0000);
        chk_cdb("rr_res_r3", 6'd7, 32'd7);
        tick();
        chk_cdb("rr_res_r0b", 6'd1, 32'd30);
        tick();
        chk("rr_drained", cdb_valid, 0);

        // Single requester 2 issuing SUB back-to-back.
        pkt[2] = mk(1'b1, ARITH_ADD_SUB, 32'd2, 32'd1, 6'd9);
        tick();
        req_valid = 4'b0100;
        #1;
        chk("sub_gnt_a", req_ready, 4'b0100);
        chk("sub_fu_ai", fu_ai, 1);
        chk("sub_fu_type", fu_type, 0);
        tick();
        chk("sub_gnt_b", req_ready, 4'b0100);
        chk("sub_cdb_empty", cdb_valid, 0);
        tick();
        chk("sub_gnt_c", req_ready, 4'b0100);
        chk_cdb("sub_res_a", 6'd9, 32'd1);
        tick();
        req_valid = '0;
        #1;
        chk("sub_no_gnt", req_ready, 4'b0000);
        chk_cdb("sub_res_b", 6'd9, 32'd1);
        tick();
        chk_cdb("sub_res_c", 6'd9, 32'd1);
        tick();
        chk("sub_drained", cdb_valid, 0);
        base_pkts();

        // CDB backpressure: credits stop issue after two grants.
        tick();
        cdb_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("bp_gnt3", req_ready, 4'b1000);
        tick();
        chk("bp_gnt0", req_ready, 4'b0001);
        tick();
        chk("bp_stall_a", req_ready, 4'b0000);
        chk_cdb("bp_head_a", 6'd7, 32'd7);
        tick();
        chk("bp_stall_b", req_ready, 4'b0000);
        chk("bp_credits0", dut.credits_q, 0);
        chk_cdb("bp_head_b", 6'd7, 32'd7);
        tick();
        cdb_ready = 1'b1;
        #1;
        chk_cdb("bp_pop_r3", 6'd7, 32'd7);
        chk("bp_resume_gnt1", req_ready, 4'b0010);
        tick();
        chk_cdb("bp_pop_r0", 6'd1, 32'd30);
        chk("bp_gnt2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk_cdb("bp_res_r1", 6'd5, 32'h8000_0000);
        tick();
        chk_cdb("bp_res_r2", 6'd2, 32'd300);
        tick();
        chk("bp_drained", cdb_valid, 0);

        // SLT then SLTU on the same operands.
        pkt[0] = mk(1'b0, ARITH_SLT, 32'hFFFF_FFFF, 32'd1, 6'd3);
        pkt[1] = mk(1'b0, ARITH_SLTU, 32'hFFFF_FFFF, 32'd1, 6'd4);
        tick();
        req_valid = 4'b0011;
        #1;
        chk("cmp_gnt0", req_ready, 4'b0001);
        chk("cmp_fu_type_slt", fu_type, 2);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("cmp_gnt1", req_ready, 4'b0010);
        chk("cmp_fu_type_sltu", fu_type, 3);
        tick();
        req_valid = '0;
        #1;
        chk_cdb("cmp_slt", 6'd3, 32'd1);
        tick();
        chk_cdb("cmp_sltu", 6'd4, 32'd0);
        tick();
        chk("cmp_drained", cdb_valid, 0);
        base_pkts();

        // Flush one cycle after a grant.
        tick();
        req_valid = 4'b0010;
        #1;
        chk("fl_gnt1", req_ready, 4'b0010);
        tick();
        req_valid = 4'hF;
        flush     = 1'b1;
        #1;
        chk("fl_no_gnt", req_ready, 4'b0000);
        chk("fl_no_fu_valid", fu_vi, 0);
        tick();
        flush     = 1'b0;
        req_valid = '0;
        #1;
        chk("fl_credits", dut.credits_q, 2);
        chk("fl_dropped", cdb_valid, 0);
        tick();
        req_valid = 4'hF;
        #1;
        chk("fl_rr_continue", req_ready, 4'b0100);
        chk("fl_still_empty", cdb_valid, 0);
        tick();
        req_valid = '0;
        #1;
        chk("fl_latency", cdb_valid, 0);
        tick();
        chk_cdb("fl_res_r2", 6'd2, 32'd300);
        tick();
        chk("fl_drained", cdb_valid, 0);

        // Async reset while one result is buffered.
        tick();
        req_valid = 4'b0010;
        cdb_ready = 1'b0;
        #1;
        chk("ar_gnt1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        #1;
        chk("ar_empty", cdb_valid, 0);
        tick();
        chk_cdb("ar_buffered", 6'd5, 32'h8000_0000);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cdb_valid", cdb_valid, 0);
        chk("ar_cdb_tag", cdb_tag, 0);
        chk("ar_cdb_result", cdb_result, 0);
        #2;
        rst       = 1'b0;
        cdb_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("ar_first_gnt", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("ar_lat_empty", cdb_valid, 0);
        tick();
        chk_cdb("ar_res_r0", 6'd1, 32'd30);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
